cdb_arbiter: RTL and testbench

- Round-robin arbiter that shares the single common data bus (CDB) among the functional units that complete instructions: ALU, branch unit, load unit and store-address unit.
- Each cycle it grants at most one pending result, registers it and drives it onto the CDB broadcast lines.
- The CDB feeds the ROB's entry, value, address and is-branch inputs, the reservation stations and the register-lock logic.
- On a branch-mispredict flush it drops pending work, so squashed results never reach the ROB.

---
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among the completing units.
// Grants one pending result per cycle and broadcasts it one cycle later.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LOCK_W  = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter logic [LOCK_W-1:0] NO_LOCK = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*LOCK_W-1:0] req_entry,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_is_branch,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [LOCK_W-1:0]         cdb_entry,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [ADDR_W-1:0]         cdb_addr,
    output logic                      cdb_is_branch,
    output logic [2:0]                busy_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [LOCK_W-1:0] entry_q, entry_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              br_q, br_d;
    logic [2:0]        busy_q, busy_d;

    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_en;
    int                j;

    // Circular search starting at the priority pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_found && req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(j);
            end
        end
    end

    assign gnt_en = rst && !flush && gnt_found;

    always_comb begin
        req_grant = '0;
        if (gnt_en) req_grant[gnt_idx] = 1'b1;
    end

    always_comb begin
        ptr_d   = ptr_q;
        entry_d = NO_LOCK;
        value_d = value_q;
        addr_d  = addr_q;
        br_d    = br_q;
        busy_d  = 3'($countones(req_valid));
        if (gnt_en) begin
            ptr_d   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            entry_d = req_entry[gnt_idx*LOCK_W +: LOCK_W];
            value_d = req_value[gnt_idx*DATA_W +: DATA_W];
            addr_d  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
            br_d    = req_is_branch[gnt_idx];
            busy_d  = busy_d - 3'd1;
        end
        if (flush) busy_d = 3'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            entry_q <= NO_LOCK;
            value_q <= '0;
            addr_q  <= '0;
            br_q    <= 1'b0;
            busy_q  <= 3'd0;
        end else begin
            ptr_q   <= ptr_d;
            entry_q <= entry_d;
            value_q <= value_d;
            addr_q  <= addr_d;
            br_q    <= br_d;
            busy_q  <= busy_d;
        end
    end

    assign cdb_entry     = entry_q;
    assign cdb_value     = value_q;
    assign cdb_addr      = addr_q;
    assign cdb_is_branch = br_q;
    assign busy_cnt      = busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-free behavioural model.
module tb_cdb_arbiter;

    localparam logic [3:0] NOL = 4'hF;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [15:0]  req_entry;
    logic [127:0] req_value;
    logic [127:0] req_addr;
    logic [3:0]   req_is_branch;
    logic [3:0]   req_grant;
    logic [3:0]   cdb_entry;
    logic [31:0]  cdb_value;
    logic [31:0]  cdb_addr;
    logic         cdb_is_branch;
    logic [2:0]   busy_cnt;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_entry(req_entry),
        .req_value(req_value), .req_addr(req_addr),
        .req_is_branch(req_is_branch), .req_grant(req_grant),
        .cdb_entry(cdb_entry), .cdb_value(cdb_value),
        .cdb_addr(cdb_addr), .cdb_is_branch(cdb_is_branch),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]  ent [4];
    logic [31:0] val [4];
    logic [31:0] adr [4];
    logic        brf [4];

    int          m_ptr;
    logic [3:0]  m_entry;
    logic [31:0] m_value;
    logic [31:0] m_addr;
    logic        m_br;
    int          m_busy;
    int          last_gi;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_entry = NOL; m_value = 0;
        m_addr = 0; m_br = 0; m_busy = 0;
    endtask

    // One clock: drive at edge+1, check grant mid-cycle, outputs after edge
    task automatic cycle(input logic [3:0] v, input logic fl);
        int gi, pc;
        for (int i = 0; i < 4; i++) begin
            req_entry[i*4 +: 4]     = ent[i];
            req_value[i*32 +: 32]   = val[i];
            req_addr[i*32 +: 32]    = adr[i];
            req_is_branch[i]        = brf[i];
        end
        req_valid = v;
        flush = fl;
        #4;
        gi = -1;
        if (!fl)
            for (int k = 0; k < 4; k++)
                if (gi < 0 && v[(m_ptr + k) % 4]) gi = (m_ptr + k) % 4;
        check("grant", 64'(req_grant), (gi >= 0) ? 64'(1 << gi) : 64'd0);
        pc = $countones(v);
        m_busy = fl ? 0 : pc - ((gi >= 0) ? 1 : 0);
        if (gi >= 0) begin
            m_entry = ent[gi]; m_value = val[gi];
            m_addr = adr[gi]; m_br = brf[gi];
            m_ptr = (gi + 1) % 4;
        end else begin
            m_entry = NOL;
        end
        last_gi = gi;
        @(posedge clk);
        #1;
        check("cdb_entry", 64'(cdb_entry), 64'(m_entry));
        check("cdb_value", 64'(cdb_value), 64'(m_value));
        check("cdb_addr", 64'(cdb_addr), 64'(m_addr));
        check("cdb_is_branch", 64'(cdb_is_branch), 64'(m_br));
        check("busy_cnt", 64'(busy_cnt), 64'(m_busy));
    endtask

    logic [3:0] pend;

    initial begin
        rst = 1'b0; flush = 1'b0; req_valid = 4'b1111;
        req_entry = '0; req_value = '0; req_addr = '0; req_is_branch = '0;
        for (int i = 0; i < 4; i++) begin
            ent[i] = 4'(i); val[i] = 0; adr[i] = 0; brf[i] = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 64'(req_grant), 64'd0);
        check("rst_entry", 64'(cdb_entry), 64'(NOL));
        check("rst_value", 64'(cdb_value), 64'd0);
        check("rst_addr", 64'(cdb_addr), 64'd0);
        check("rst_br", 64'(cdb_is_branch), 64'd0);
        check("rst_busy", 64'(busy_cnt), 64'd0);
        rst = 1'b1;

        ent[0] = 4'd3; val[0] = 32'h1234;
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ent[i] = 4'(i); val[i] = 32'h100 + i; adr[i] = 32'hA000 + i;
        end
        repeat (8) cycle(4'b1111, 1'b0);

        cycle(4'b0100, 1'b0);
        cycle(4'b1001, 1'b0);
        cycle(4'b0001, 1'b0);

        ent[1] = 4'd5; val[1] = 32'h2; brf[1] = 1'b1;
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        brf[1] = 1'b0;

        cycle(4'b0001, 1'b0);
        cycle(4'b0110, 1'b1);
        cycle(4'b0110, 1'b0);

        // Requesters hold until granted; flush squashes their pending work
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            logic fl;
            for (int i = 0; i < 4; i++)
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1'b1;
                    ent[i] = 4'($urandom_range(0, 14));
                    val[i] = $urandom;
                    adr[i] = $urandom;
                    brf[i] = 1'($urandom_range(0, 1));
                end
            fl = ($urandom_range(0, 9) == 0);
            cycle(pend, fl);
            if (fl) pend = '0;
            else if (last_gi >= 0) pend[last_gi] = 1'b0;
        end

        ent[2] = 4'd2;
        cycle(4'b0100, 1'b0);
        req_valid = 4'b1111;
        flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_entry", 64'(cdb_entry), 64'(NOL));
        check("arst_busy", 64'(busy_cnt), 64'd0);
        check("arst_grant", 64'(req_grant), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(4'b1111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
